// File: rtl/mul_limb_pkg.sv
// mul_limb_pkg: shared types and defaults for the sequential limb multiplier.
//   mul_state_e  - FSM state encoding (IDLE, MUL, DONE)
//   W_DEF/N_DEF  - default limb width and limbs per operand
//   idx_width()  - width of the i/j limb counters, never below 1 bit
package mul_limb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } mul_state_e;

    localparam int W_DEF = 16;
    localparam int N_DEF = 2;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mul_limb_seq_limb_mul.sv
// limb_mul: combinational W x W -> 2W unsigned limb multiplier.
//   a, b : W-bit unsigned limbs
//   p    : 2W-bit exact product
module limb_mul #(
    parameter int W = 16
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] p
);

    assign p = (2*W)'(a) * (2*W)'(b);

endmodule

// File: rtl/mul_limb_seq.sv
// mul_limb_seq: sequential schoolbook multiplier, N-limb x N-limb -> 2N-limb,
// one limb product per cycle, valid/ready on both sides.
//   clk, rst             - rising-edge clock, synchronous active-high reset
//   in_valid / in_ready  - operand handshake; a and b sampled on accept only
//   a, b                 - N*W-bit operands, limb k = [k*W +: W]
//   out_valid / out_ready- result handshake; y held until out_ready
//   y                    - 2*N*W-bit product, updated only on entry to DONE
//   busy                 - high whenever the FSM is not in IDLE
// Optional build macro MUL_LIMB_SEQ_ZERO_SKIP_EN: a row whose A limb is zero
// is collapsed into a single cycle. Product values are identical either way.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// MUL   | one limb product accumulated per cycle, j inner, i outer
// DONE  | product presented on y with out_valid, waiting for out_ready
module mul_limb_seq
    import mul_limb_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int N = N_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*W-1:0]   a,
    input  logic [N*W-1:0]   b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N*W-1:0] y,
    output logic             busy
);

    localparam int IW = idx_width(N);
    localparam int AW = 2 * N * W;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    mul_state_e      state;
    logic [N*W-1:0]  a_reg;
    logic [N*W-1:0]  b_reg;
    logic [AW-1:0]   acc;
    logic [AW-1:0]   acc_next;
    logic [IW-1:0]   i;
    logic [IW-1:0]   j;
    logic [W-1:0]    a_limb;
    logic [W-1:0]    b_limb;
    logic [2*W-1:0]  p;
    logic            skip_row;
    logic            last_step;

    assign a_limb = a_reg[int'(i)*W +: W];
    assign b_limb = b_reg[int'(j)*W +: W];

    limb_mul #(.W(W)) u_limb_mul (
        .a (a_limb),
        .b (b_limb),
        .p (p)
    );

    always_comb begin
        skip_row = 1'b0;
`ifdef MUL_LIMB_SEQ_ZERO_SKIP_EN
        // Only decided at the start of a row so a partially summed row never aborts.
        skip_row = (j == '0) && (a_limb == '0);
`endif
        // Full-width add: carries ripple through every upper limb.
        acc_next  = skip_row ? acc : acc + (AW'(p) << (W * (int'(i) + int'(j))));
        last_step = (i == LAST) && (skip_row || (j == LAST));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            i         <= '0;
            j         <= '0;
            y         <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_reg    <= a;
                        b_reg    <= b;
                        acc      <= '0;
                        i        <= '0;
                        j        <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= MUL;
                    end
                end
                MUL: begin
                    acc <= acc_next;
                    if (last_step) begin
                        y         <= acc_next;
                        out_valid <= 1'b1;
                        i         <= '0;
                        j         <= '0;
                        state     <= DONE;
                    end else if (skip_row || (j == LAST)) begin
                        j <= '0;
                        i <= i + 1'b1;
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_limb_seq.sv
// tb_mul_limb_seq: directed, table-driven bench for mul_limb_seq at W=16, N=2.
// Expected latencies follow MUL_LIMB_SEQ_ZERO_SKIP_EN when it is defined.
module tb_mul_limb_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] y;
    logic        busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mul_limb_seq #(.W(16), .N(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .busy      (busy)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] y;
    } vec_t;

    vec_t vecs[8];

    function automatic int exp_lat(input logic [31:0] av);
        int l;
`ifdef MUL_LIMB_SEQ_ZERO_SKIP_EN
        l = 1;
        l += (av[15:0]  == 16'h0) ? 1 : 2;
        l += (av[31:16] == 16'h0) ? 1 : 2;
`else
        l = 5;
`endif
        return l;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Starts from IDLE; returns at the negedge where out_valid was first seen.
    // lat counts clock edges from the accept edge (inclusive) to out_valid.
    task automatic run_op(input logic [31:0] av, input logic [31:0] bv,
                          output logic [63:0] yv, output int lat);
        @(negedge clk);
        a = av;
        b = bv;
        in_valid = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        yv = y;
    endtask

    logic [63:0] yv;
    int          lat;
    int          cnt;
    logic [31:0] bb_a[3];
    logic [31:0] bb_b[3];
    logic [63:0] bb_y[3];

    initial begin
        vecs[0] = '{32'h0001_0002, 32'h0003_0004, 64'h0000_0003_000A_0008};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vecs[2] = '{32'h0000_1234, 32'h0002_0001, 64'h0000_0000_2468_1234};
        vecs[3] = '{32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000};
        vecs[4] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};
        vecs[5] = '{32'hFFFF_FFFF, 32'h0000_0001, 64'h0000_0000_FFFF_FFFF};
        vecs[6] = '{32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001};
        vecs[7] = '{32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000};

        bb_a = '{32'h0001_0002, 32'hFFFF_FFFF, 32'h0003_0005};
        bb_b = '{32'h0003_0004, 32'hFFFF_FFFF, 32'h0007_000B};
        bb_y = '{64'h0000_0003_000A_0008, 64'hFFFF_FFFE_0000_0001, 64'h0000_0015_0044_0037};

        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_y", y, 64'd0);
        rst = 1'b0;

        // Table-driven products and latencies.
        for (int k = 0; k < 8; k++) begin
            run_op(vecs[k].a, vecs[k].b, yv, lat);
            chk($sformatf("vec%0d_y", k), yv, vecs[k].y);
            chk($sformatf("vec%0d_lat", k), 64'(lat), 64'(exp_lat(vecs[k].a)));
        end

        // Stall: out_ready low for 10 cycles, new operands offered meanwhile.
        @(negedge clk);
        out_ready = 1'b0;
        run_op(32'h0001_0002, 32'h0003_0004, yv, lat);
        chk("stall_y", yv, 64'h0000_0003_000A_0008);
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            a = 32'hDEAD_BEEF;
            b = 32'h1111_2222;
            @(negedge clk);
            chk($sformatf("stall%0d_out_valid", k), 64'(out_valid), 64'd1);
            chk($sformatf("stall%0d_y", k), y, 64'h0000_0003_000A_0008);
            chk($sformatf("stall%0d_in_ready", k), 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("drain_out_valid", 64'(out_valid), 64'd0);
        chk("drain_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        chk("drain_no_accept", 64'(busy), 64'd0);
        chk("drain_y_held", y, 64'h0000_0003_000A_0008);

        // Reset during the second MUL cycle.
        a = 32'hFFFF_FFFF;
        b = 32'hFFFF_FFFF;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mul_busy", 64'(busy), 64'd1);
        chk("mul_y_not_live", y, 64'h0000_0003_000A_0008);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", 64'(in_ready), 64'd1);
        chk("abort_out_valid", 64'(out_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_y", y, 64'd0);
        run_op(32'd2, 32'd3, yv, lat);
        chk("after_abort_y", yv, 64'd6);
        chk("after_abort_lat", 64'(lat), 64'(exp_lat(32'd2)));

        // Back-to-back with in_valid and out_ready held high.
        @(negedge clk);
        @(negedge clk);
        a = bb_a[0];
        b = bb_b[0];
        in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cnt = 0;
            do begin
                @(posedge clk);
                cnt++;
                @(negedge clk);
            end while (!out_valid && cnt < 50);
            chk($sformatf("b2b%0d_y", k), y, bb_y[k]);
            chk($sformatf("b2b%0d_period", k), 64'(cnt), (k == 0) ? 64'd5 : 64'd6);
            if (k < 2) begin
                a = bb_a[k+1];
                b = bb_b[k+1];
            end
        end
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("b2b_idle", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
